// File: rtl/boreal_ai_result_writer.sv
// AI result-stream packer: writes each frame into a ping-pong mailbox slot over MMIO,
// then writes the header word and raises the slot's valid flag.
module boreal_ai_result_writer #(
  parameter logic [31:0] MB_BASE   = 32'h0000_0000,
  parameter int          MAX_WORDS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        mb_sel,
  output logic        mb_wr,
  output logic [31:0] mb_addr,
  output logic [31:0] mb_wdata,
  input  logic        mb_ack,
  input  logic        slot0_valid,
  input  logic        slot1_valid,
  output logic        busy,
  output logic        cur_slot,
  output logic [15:0] frame_cnt,
  output logic [15:0] trunc_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_DROP   = 3'd2,
    S_HDR    = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  localparam logic [4:0]  LAST_WI    = 5'(MAX_WORDS);
  localparam logic [31:0] SLOT0_BASE = 32'h0000_0040;
  localparam logic [31:0] SLOT1_BASE = 32'h0000_0080;
  localparam logic [31:0] VALID0_OFF = 32'h0000_0000;
  localparam logic [31:0] VALID1_OFF = 32'h0000_0004;

  // len is the number of payload words written, i.e. one less than the next word index
  function automatic logic [31:0] build_header(input logic [15:0] cnt,
                                               input logic        trunc,
                                               input logic [4:0]  wi);
    return {cnt, 7'd0, trunc, 4'd0, 4'(wi - 5'd1)};
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  wi_q, wi_d;
  logic        trunc_q, trunc_d;
  logic        last_pend_q, last_pend_d;
  logic        mb_sel_q, mb_sel_d;
  logic [31:0] mb_addr_q, mb_addr_d;
  logic [31:0] mb_wdata_q, mb_wdata_d;
  logic        cur_slot_q, cur_slot_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] trunc_cnt_q, trunc_cnt_d;

  logic        in_ready_c;
  logic        slot_busy;
  logic        wr_done;
  logic        accept;
  logic [31:0] slot_base;

  assign slot_busy = cur_slot_q ? slot1_valid : slot0_valid;
  assign wr_done   = mb_sel_q && mb_ack;
  assign accept    = in_valid && in_ready_c;
  assign slot_base = cur_slot_q ? SLOT1_BASE : SLOT0_BASE;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wi_q        <= 5'd0;
      trunc_q     <= 1'b0;
      last_pend_q <= 1'b0;
      mb_sel_q    <= 1'b0;
      mb_addr_q   <= 32'd0;
      mb_wdata_q  <= 32'd0;
      cur_slot_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
      trunc_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wi_q        <= wi_d;
      trunc_q     <= trunc_d;
      last_pend_q <= last_pend_d;
      mb_sel_q    <= mb_sel_d;
      mb_addr_q   <= mb_addr_d;
      mb_wdata_q  <= mb_wdata_d;
      cur_slot_q  <= cur_slot_d;
      frame_cnt_q <= frame_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  // Next-state logic; a data state only moves on once its pending write has completed
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable && in_valid && !slot_busy) begin
          state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (wr_done && last_pend_q) begin
          state_d = S_HDR;
        end else if (wr_done && (wi_q > LAST_WI)) begin
          state_d = S_DROP;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DROP: begin
        if (accept && in_last) begin
          state_d = S_HDR;
        end else begin
          state_d = S_DROP;
        end
      end
      S_HDR: begin
        if (wr_done) begin
          state_d = S_COMMIT;
        end else begin
          state_d = S_HDR;
        end
      end
      S_COMMIT: begin
        if (wr_done) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_COMMIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from registered state
  always_comb begin
    in_ready_c = 1'b0;
    case (state_q)
      S_DATA:  in_ready_c = !mb_sel_q && (wi_q <= LAST_WI);
      S_DROP:  in_ready_c = 1'b1;
      default: in_ready_c = 1'b0;
    endcase
  end

  // MMIO transaction, word index and counter updates
  always_comb begin
    wi_d        = wi_q;
    trunc_d     = trunc_q;
    last_pend_d = last_pend_q;
    mb_addr_d   = mb_addr_q;
    mb_wdata_d  = mb_wdata_q;
    cur_slot_d  = cur_slot_q;
    frame_cnt_d = frame_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    if (wr_done) begin
      mb_sel_d = 1'b0;
    end else begin
      mb_sel_d = mb_sel_q;
    end
    case (state_q)
      S_IDLE: begin
        if (state_d == S_DATA) begin
          wi_d        = 5'd1;
          trunc_d     = 1'b0;
          last_pend_d = 1'b0;
        end else begin
          wi_d = wi_q;
        end
      end
      S_DATA: begin
        if (accept) begin
          mb_sel_d    = 1'b1;
          mb_addr_d   = MB_BASE + slot_base + {25'd0, wi_q, 2'b00};
          mb_wdata_d  = in_data;
          wi_d        = wi_q + 5'd1;
          last_pend_d = in_last;
        end else if (wr_done && !last_pend_q && (wi_q > LAST_WI)) begin
          trunc_d = 1'b1;
        end else begin
          wi_d = wi_q;
        end
      end
      S_HDR: begin
        if (!mb_sel_q) begin
          mb_sel_d   = 1'b1;
          mb_addr_d  = MB_BASE + slot_base;
          mb_wdata_d = build_header(frame_cnt_q, trunc_q, wi_q);
        end else begin
          mb_addr_d = mb_addr_q;
        end
      end
      S_COMMIT: begin
        if (!mb_sel_q) begin
          mb_sel_d   = 1'b1;
          mb_addr_d  = MB_BASE + (cur_slot_q ? VALID1_OFF : VALID0_OFF);
          mb_wdata_d = 32'h0000_0001;
        end else if (wr_done) begin
          cur_slot_d  = !cur_slot_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (trunc_q && (trunc_cnt_q != 16'hFFFF)) begin
            trunc_cnt_d = trunc_cnt_q + 16'd1;
          end else begin
            trunc_cnt_d = trunc_cnt_q;
          end
        end else begin
          mb_addr_d = mb_addr_q;
        end
      end
      default: begin
        wi_d = wi_q;
      end
    endcase
  end

  assign in_ready  = in_ready_c;
  assign busy      = (state_q != S_IDLE);
  assign mb_sel    = mb_sel_q;
  assign mb_wr     = mb_sel_q;
  assign mb_addr   = mb_addr_q;
  assign mb_wdata  = mb_wdata_q;
  assign cur_slot  = cur_slot_q;
  assign frame_cnt = frame_cnt_q;
  assign trunc_cnt = trunc_cnt_q;

  boreal_ai_result_writer_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .mb_sel   (mb_sel_q),
    .mb_wr    (mb_wr),
    .mb_ack   (mb_ack),
    .in_ready (in_ready_c),
    .mb_addr  (mb_addr_q),
    .mb_wdata (mb_wdata_q)
  );

endmodule

// Protocol properties of the mailbox write port.
module boreal_ai_result_writer_chk (
  input logic        clk,
  input logic        rst,
  input logic        mb_sel,
  input logic        mb_wr,
  input logic        mb_ack,
  input logic        in_ready,
  input logic [31:0] mb_addr,
  input logic [31:0] mb_wdata
);

  a_wr_eq_sel: assert property (@(posedge clk) mb_wr == mb_sel);

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (mb_sel && !mb_ack) |=> (mb_sel && $stable(mb_addr) && $stable(mb_wdata)));

  a_no_accept_while_busy: assert property (@(posedge clk) !(mb_sel && in_ready));

endmodule

// File: tb/tb_boreal_ai_result_writer.sv
// Randomized scoreboard bench: frames are expanded into expected MMIO writes from the
// slot/header rules, and a negedge monitor acks writes and pops/compares them.
module tb_boreal_ai_result_writer;

  localparam logic [31:0] MB_BASE = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        mb_sel;
  logic        mb_wr;
  logic [31:0] mb_addr;
  logic [31:0] mb_wdata;
  logic        mb_ack = 1'b0;
  logic        slot0_valid = 1'b0;
  logic        slot1_valid = 1'b0;
  logic        busy;
  logic        cur_slot;
  logic [15:0] frame_cnt;
  logic [15:0] trunc_cnt;

  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];
  logic        exp_slot;
  logic [15:0] exp_fc;
  logic [15:0] exp_tc;
  logic        hold_ack = 1'b0;
  logic        vm_hold = 1'b1;

  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;
  wr_t         mon_e;

  boreal_ai_result_writer #(.MB_BASE(MB_BASE), .MAX_WORDS(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .mb_sel      (mb_sel),
    .mb_wr       (mb_wr),
    .mb_addr     (mb_addr),
    .mb_wdata    (mb_wdata),
    .mb_ack      (mb_ack),
    .slot0_valid (slot0_valid),
    .slot1_valid (slot1_valid),
    .busy        (busy),
    .cur_slot    (cur_slot),
    .frame_cnt   (frame_cnt),
    .trunc_cnt   (trunc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: random ack, scoreboard pop, hold stability, and a VM that clears slot flags
  always @(negedge clk) begin
    if (rst) begin
      mb_ack = 1'b0;
      prev_pend = 1'b0;
    end else begin
      if (mb_sel) begin
        chk("mb_wr", {31'd0, mb_wr}, 32'd1);
        chk("ready_during_write", {31'd0, in_ready}, 32'd0);
        if (prev_pend) begin
          chk("hold_addr_stable", mb_addr, prev_addr);
          chk("hold_wdata_stable", mb_wdata, prev_wdata);
        end
        if (!hold_ack && ($urandom_range(0, 3) != 0)) begin
          mb_ack = 1'b1;
          prev_pend = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write addr=%h data=%h expected=none", mb_addr, mb_wdata);
          end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", mb_addr, mon_e.addr);
            chk("wr_data", mb_wdata, mon_e.data);
          end
          if (mb_addr == MB_BASE) slot0_valid = 1'b1;
          if (mb_addr == MB_BASE + 32'd4) slot1_valid = 1'b1;
        end else begin
          mb_ack = 1'b0;
          prev_pend = 1'b1;
          prev_addr = mb_addr;
          prev_wdata = mb_wdata;
        end
      end else begin
        mb_ack = 1'b0;
        prev_pend = 1'b0;
      end
      if (!vm_hold) begin
        if (slot0_valid && ($urandom_range(0, 5) == 0)) slot0_valid = 1'b0;
        if (slot1_valid && ($urandom_range(0, 5) == 0)) slot1_valid = 1'b0;
      end
    end
  end

  task automatic give_up(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=progress", name);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      t++;
      if (t > 1000) give_up("beat_accept");
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && (t < 1000));
    if (t >= 1000) give_up(name);
  endtask

  // Reference: a frame of n beats becomes min(n,15) data writes, a header and a valid write
  task automatic send_frame(input int n, input bit toggle_en);
    logic [31:0] beats[$];
    int          nw;
    logic        tr;
    logic [31:0] sb;
    for (int i = 0; i < n; i++) beats.push_back($urandom());
    nw = (n > 15) ? 15 : n;
    tr = (n > 15);
    sb = exp_slot ? 32'h0000_0080 : 32'h0000_0040;
    for (int k = 1; k <= nw; k++) exp_q.push_back('{addr: MB_BASE + sb + 32'(4 * k), data: beats[k-1]});
    exp_q.push_back('{addr: MB_BASE + sb, data: {exp_fc, 7'd0, tr, 4'd0, 4'(nw)}});
    exp_q.push_back('{addr: MB_BASE + (exp_slot ? 32'd4 : 32'd0), data: 32'd1});
    exp_slot = !exp_slot;
    exp_fc   = exp_fc + 16'd1;
    if (tr && (exp_tc != 16'hFFFF)) exp_tc = exp_tc + 16'd1;
    for (int i = 0; i < n; i++) begin
      send_beat(beats[i], (i == n - 1));
      if (toggle_en && (i == 0)) enable = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    enable   = 1'b1;
    wait_idle("frame_done");
    chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});
    chk("trunc_cnt", {16'd0, trunc_cnt}, {16'd0, exp_tc});
    chk("cur_slot", {31'd0, cur_slot}, {31'd0, exp_slot});
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t;
    int lens[5];
    logic [31:0] sb;
    lens = '{15, 16, 1, 14, 17};
    rst = 1'b1; enable = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b0;
    exp_slot = 1'b0; exp_fc = 16'd0; exp_tc = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mb_sel", {31'd0, mb_sel}, 32'd0);
    chk("rst_mb_wr", {31'd0, mb_wr}, 32'd0);
    chk("rst_mb_addr", mb_addr, 32'd0);
    chk("rst_mb_wdata", mb_wdata, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cur_slot", {31'd0, cur_slot}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_trunc_cnt", {16'd0, trunc_cnt}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;

    send_frame(3, 1'b0);
    send_frame(2, 1'b0);

    // Both slots held valid by the VM: no frame may start, and enable=0 also blocks it
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    repeat (8) begin
      @(negedge clk);
      chk("blocked_busy", {31'd0, busy}, 32'd0);
      chk("blocked_ready", {31'd0, in_ready}, 32'd0);
    end
    enable  = 1'b0;
    vm_hold = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("disabled_busy", {31'd0, busy}, 32'd0);
    end
    in_valid = 1'b0;
    enable   = 1'b1;

    send_frame(20, 1'b0);
    for (int i = 0; i < 5; i++) send_frame(lens[i], 1'b0);
    for (int i = 0; i < 20; i++) send_frame($urandom_range(1, 22), 1'(($urandom_range(0, 1))));

    // Write held without ack, then reset mid-frame
    hold_ack = 1'b1;
    sb = exp_slot ? 32'h0000_0080 : 32'h0000_0040;
    in_valid = 1'b1;
    in_data  = 32'hCAFE_0001;
    in_last  = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mb_sel && (t < 1000));
    if (t >= 1000) give_up("hold_start");
    chk("held_addr", mb_addr, MB_BASE + sb + 32'd4);
    chk("held_wdata", mb_wdata, 32'hCAFE_0001);
    in_data = 32'hCAFE_0002;
    repeat (5) begin
      @(negedge clk);
      chk("held_sel", {31'd0, mb_sel}, 32'd1);
      chk("held_ready", {31'd0, in_ready}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mb_sel", {31'd0, mb_sel}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("midrst_trunc_cnt", {16'd0, trunc_cnt}, 32'd0);
    chk("midrst_cur_slot", {31'd0, cur_slot}, 32'd0);
    in_valid = 1'b0;
    hold_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
